minsoc_rst_sequencer: RTL and testbench
=======================================

Name: minsoc_rst_sequencer

Overview:
- Central reset controller for minsoc. Takes the board reset plus soft-reset requests from the external button, watchdog, debug unit and a software register.
- Holds every subsystem in reset for a minimum time, then releases the domains in a fixed order: interconnect, then peripherals and ethernet, then CPU.
- Records which source(s) caused the last reset, so firmware can read the cause.
- Sits between the top-level `clock`/`reset` pins and all module resets in minsoc_top.

Parameters:
- HOLD_CYCLES, 16: cycles all domain resets stay asserted after the last trigger; must be >= 2.
- STAGE_GAP, 4: cycles between successive release stages; must be >= 1.
- DEBOUNCE, 8: consecutive stable cycles required before the synchronised button level is accepted; must be >= 1.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high block reset (the board/power-on reset).
- ext_rst_req  in  1  external reset button; asynchronous, active-high level.
- wdt_rst_req  in  1  watchdog reset request; synchronous one-cycle pulse.
- dbg_rst_req  in  1  debug-unit reset request; synchronous pulse.
- sw_rst_req  in  1  software reset-register write strobe; synchronous pulse.
- rst_ic  out  1  interconnect/wishbone reset, active-high.
- rst_periph  out  1  uart/gpio/memory reset, active-high.
- rst_eth  out  1  ethernet MAC reset, active-high.
- rst_cpu  out  1  or1200 reset, active-high.
- seq_busy  out  1  high while any domain reset is asserted.
- rst_cause  out  5  cause bits: [0] por, [1] ext, [2] wdt, [3] dbg, [4] sw.

Behaviour:
- All outputs are registered.
- While reset=1:
  - state=ASSERT, counter=0.
  - rst_ic, rst_periph, rst_eth, rst_cpu and seq_busy are all 1.
  - rst_cause=5'b00001.
  - Debounce logic is cleared (debounced ext=0).
- States: ASSERT -> REL_IC -> REL_PER -> RUN.
  - Counter width is clog2(max(HOLD_CYCLES, STAGE_GAP)) + 1.
- ASSERT:
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES-1: go to REL_IC, rst_ic<=0, counter<=0.
- REL_IC:
  - When counter==STAGE_GAP-1: go to REL_PER, rst_periph<=0 and rst_eth<=0 in the same cycle, counter<=0.
- REL_PER:
  - When counter==STAGE_GAP-1: go to RUN, rst_cpu<=0, seq_busy<=0.
- Release timing with defaults: counting rising edges after reset is first sampled 0 as edge 1:
  - rst_ic falls at edge 16.
  - rst_periph and rst_eth fall at edge 20.
  - rst_cpu and seq_busy fall at edge 24.
- Trigger = debounced ext rising event, or wdt_rst_req, or dbg_rst_req, or sw_rst_req.
- Trigger while in RUN:
  - Next edge: state=ASSERT, counter=0, all four resets and seq_busy=1.
  - rst_cause is replaced by the OR of all sources active that cycle (por bit=0).
- Trigger while in ASSERT, REL_IC or REL_PER:
  - Restart: state=ASSERT, counter=0.
  - Any released resets re-assert.
  - New cause bits are ORed into rst_cause (sticky within one sequence).
- Debounced ext held high: counter is forced to 0 in ASSERT, so reset lasts the whole press plus HOLD_CYCLES.
- Button retrigger: a new ext trigger requires the debounced level to fall and rise again.
- Ext path:
  - 2-FF synchroniser feeds the debouncer.
  - The debounced value flips only after the synchronised level has differed from it for DEBOUNCE consecutive cycles.
  - Shorter pulses are ignored.
- reset=1 mid-sequence overrides everything and returns to the reset values above.

Decomposition:
- Shared include file minsoc_rst_defines.v holds:
  - state encodings (ASSERT=2'd0, REL_IC=2'd1, REL_PER=2'd2, RUN=2'd3);
  - cause bit indices;
  - default HOLD_CYCLES, STAGE_GAP and DEBOUNCE values.
- One sub-module: minsoc_rst_debounce, containing the synchroniser and debounce counter.
  - Ports: clock, reset, async_in, level_out, rise_pulse.

Test Plan:
1. POR: reset high 2 cycles, then low → rst_ic falls at edge 16, rst_periph/rst_eth at edge 20, rst_cpu/seq_busy at edge 24; rst_cause=5'b00001.
2. wdt_rst_req pulsed 1 cycle in RUN → all resets=1 next edge; rst_cause=5'b00100; release at +16/+20/+24 edges from the trigger edge.
3. dbg_rst_req and sw_rst_req in the same cycle in RUN → rst_cause=5'b11000. Then wdt pulse at edge 18 of that sequence → rst_ic re-asserts, counter restarts, rst_cause=5'b11100.
4. ext_rst_req high for 5 cycles → no reset activity. High for 40 cycles → resets assert ~10 edges after the rising edge and stay asserted. rst_cause=5'b00010. rst_ic falls 16 edges after the debounced level falls.
5. reset asserted while in REL_PER → all outputs=1 next edge, rst_cause=5'b00001, full 16/20/24 sequence after release.
6. Params HOLD_CYCLES=2, STAGE_GAP=1 → rst_ic falls at edge 2, rst_periph/rst_eth at edge 3, rst_cpu at edge 4.

Source files
------------

// File: rtl/minsoc_rst_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : minsoc_rst_sequencer_pkg
// Brief  : Shared state encodings, cause-bit indices and defaults for the reset
//          sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package minsoc_rst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_REL_IC  = 2'd1,
        ST_REL_PER = 2'd2,
        ST_RUN     = 2'd3
    } rst_state_t;

    localparam int c_CAUSE_W   = 5;
    localparam int c_CAUSE_POR = 0;
    localparam int c_CAUSE_EXT = 1;
    localparam int c_CAUSE_WDT = 2;
    localparam int c_CAUSE_DBG = 3;
    localparam int c_CAUSE_SW  = 4;

    localparam int c_DEF_HOLD_CYCLES = 16;
    localparam int c_DEF_STAGE_GAP   = 4;
    localparam int c_DEF_DEBOUNCE    = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/minsoc_rst_debounce.sv
//------------------------------------------------------------------------------
// Module : minsoc_rst_debounce
// Brief  : 2-FF synchroniser plus stability counter for the reset button.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module minsoc_rst_debounce
    import minsoc_rst_sequencer_pkg::*;
#(
    parameter int DEBOUNCE = c_DEF_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int c_CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            // Any return to the accepted level restarts the stability count
            if (r_sync2 != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;

endmodule

`default_nettype wire

// File: rtl/minsoc_rst_sequencer.sv
//------------------------------------------------------------------------------
// Module : minsoc_rst_sequencer
// Brief  : Central reset controller: hold, staged domain release, cause record.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module minsoc_rst_sequencer
    import minsoc_rst_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = c_DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = c_DEF_STAGE_GAP,
    parameter int DEBOUNCE    = c_DEF_DEBOUNCE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ext_rst_req,
    input  logic                 wdt_rst_req,
    input  logic                 dbg_rst_req,
    input  logic                 sw_rst_req,
    output logic                 rst_ic,
    output logic                 rst_periph,
    output logic                 rst_eth,
    output logic                 rst_cpu,
    output logic                 seq_busy,
    output logic [c_CAUSE_W-1:0] rst_cause
);

    localparam int c_CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP)) + 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);
    localparam logic [c_CAUSE_W-1:0] c_CAUSE_RST = c_CAUSE_W'(1) << c_CAUSE_POR;

    logic w_ext_level;
    logic w_ext_rise;

    minsoc_rst_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .async_in   (ext_rst_req),
        .level_out  (w_ext_level),
        .rise_pulse (w_ext_rise)
    );

    rst_state_t           r_state,    w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic                 r_rst_ic,   w_rst_ic_nxt;
    logic                 r_rst_per,  w_rst_per_nxt;
    logic                 r_rst_eth,  w_rst_eth_nxt;
    logic                 r_rst_cpu,  w_rst_cpu_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic [c_CAUSE_W-1:0] r_cause,    w_cause_nxt;
    logic [c_CAUSE_W-1:0] w_new_cause;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_rst_ic  <= 1'b1;
            r_rst_per <= 1'b1;
            r_rst_eth <= 1'b1;
            r_rst_cpu <= 1'b1;
            r_busy    <= 1'b1;
            r_cause   <= c_CAUSE_RST;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_ic  <= w_rst_ic_nxt;
            r_rst_per <= w_rst_per_nxt;
            r_rst_eth <= w_rst_eth_nxt;
            r_rst_cpu <= w_rst_cpu_nxt;
            r_busy    <= w_busy_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    always_comb begin
        w_new_cause              = '0;
        w_new_cause[c_CAUSE_EXT] = w_ext_rise;
        w_new_cause[c_CAUSE_WDT] = wdt_rst_req;
        w_new_cause[c_CAUSE_DBG] = dbg_rst_req;
        w_new_cause[c_CAUSE_SW]  = sw_rst_req;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rst_ic_nxt  = r_rst_ic;
        w_rst_per_nxt = r_rst_per;
        w_rst_eth_nxt = r_rst_eth;
        w_rst_cpu_nxt = r_rst_cpu;
        w_busy_nxt    = r_busy;
        w_cause_nxt   = r_cause;

        if (|w_new_cause) begin
            w_state_nxt   = ST_ASSERT;
            w_cnt_nxt     = '0;
            w_rst_ic_nxt  = 1'b1;
            w_rst_per_nxt = 1'b1;
            w_rst_eth_nxt = 1'b1;
            w_rst_cpu_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
            // A fresh sequence starts a fresh cause record; a restart accumulates
            w_cause_nxt   = (r_state == ST_RUN) ? w_new_cause : (r_cause | w_new_cause);
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (w_ext_level) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt  = ST_REL_IC;
                        w_cnt_nxt    = '0;
                        w_rst_ic_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_REL_IC: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt   = ST_REL_PER;
                        w_cnt_nxt     = '0;
                        w_rst_per_nxt = 1'b0;
                        w_rst_eth_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_REL_PER: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt   = ST_RUN;
                        w_cnt_nxt     = '0;
                        w_rst_cpu_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign rst_ic     = r_rst_ic;
    assign rst_periph = r_rst_per;
    assign rst_eth    = r_rst_eth;
    assign rst_cpu    = r_rst_cpu;
    assign seq_busy   = r_busy;
    assign rst_cause  = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_minsoc_rst_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_minsoc_rst_sequencer
// Brief  : Directed self-checking bench for the reset sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_minsoc_rst_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ext_rst_req, wdt_rst_req, dbg_rst_req, sw_rst_req;
    logic       rst_ic, rst_periph, rst_eth, rst_cpu, seq_busy;
    logic [4:0] rst_cause;
    logic       rst_ic2, rst_periph2, rst_eth2, rst_cpu2, seq_busy2;
    logic [4:0] rst_cause2;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;

    always #5 clock = ~clock;

    minsoc_rst_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .ext_rst_req (ext_rst_req),
        .wdt_rst_req (wdt_rst_req),
        .dbg_rst_req (dbg_rst_req),
        .sw_rst_req  (sw_rst_req),
        .rst_ic      (rst_ic),
        .rst_periph  (rst_periph),
        .rst_eth     (rst_eth),
        .rst_cpu     (rst_cpu),
        .seq_busy    (seq_busy),
        .rst_cause   (rst_cause)
    );

    minsoc_rst_sequencer #(
        .HOLD_CYCLES (2),
        .STAGE_GAP   (1)
    ) dut_small (
        .clock       (clock),
        .reset       (reset),
        .ext_rst_req (1'b0),
        .wdt_rst_req (1'b0),
        .dbg_rst_req (1'b0),
        .sw_rst_req  (1'b0),
        .rst_ic      (rst_ic2),
        .rst_periph  (rst_periph2),
        .rst_eth     (rst_eth2),
        .rst_cpu     (rst_cpu2),
        .seq_busy    (seq_busy2),
        .rst_cause   (rst_cause2)
    );

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ecnt++;
    endtask

    task automatic wait_to(input int target);
        while (ecnt < target) tick();
    endtask

    function automatic logic [4:0] outs();
        return {rst_ic, rst_periph, rst_eth, rst_cpu, seq_busy};
    endfunction

    // Expected outputs are {ic, periph, eth, cpu, busy}; edges count from ecnt=0
    task automatic check_release(input string tag);
        wait_to(15); t_check({tag, "_e15"}, 32'(outs()), 32'b11111);
        wait_to(16); t_check({tag, "_e16"}, 32'(outs()), 32'b01111);
        wait_to(19); t_check({tag, "_e19"}, 32'(outs()), 32'b01111);
        wait_to(20); t_check({tag, "_e20"}, 32'(outs()), 32'b00011);
        wait_to(23); t_check({tag, "_e23"}, 32'(outs()), 32'b00011);
        wait_to(24); t_check({tag, "_e24"}, 32'(outs()), 32'b00000);
    endtask

    initial begin
        logic busy_seen;
        reset = 1'b1;
        ext_rst_req = 1'b0; wdt_rst_req = 1'b0; dbg_rst_req = 1'b0; sw_rst_req = 1'b0;

        // 1. power-on reset
        tick(); tick();
        t_check("por_outs", 32'(outs()), 32'b11111);
        t_check("por_cause", 32'(rst_cause), 32'b00001);
        reset = 1'b0;
        ecnt = 0;
        tick(); t_check("small_e1", 32'({rst_ic2, rst_periph2, rst_eth2, rst_cpu2, seq_busy2}), 32'b11111);
        tick(); t_check("small_e2", 32'({rst_ic2, rst_periph2, rst_eth2, rst_cpu2, seq_busy2}), 32'b01111);
        tick(); t_check("small_e3", 32'({rst_ic2, rst_periph2, rst_eth2, rst_cpu2, seq_busy2}), 32'b00011);
        tick(); t_check("small_e4", 32'({rst_ic2, rst_periph2, rst_eth2, rst_cpu2, seq_busy2}), 32'b00000);
        check_release("por");
        t_check("por_cause_run", 32'(rst_cause), 32'b00001);

        // 2. watchdog pulse in RUN
        repeat (3) tick();
        wdt_rst_req = 1'b1; tick(); wdt_rst_req = 1'b0;
        ecnt = 0;
        t_check("wdt_outs", 32'(outs()), 32'b11111);
        t_check("wdt_cause", 32'(rst_cause), 32'b00100);
        check_release("wdt");

        // 3. debug + software together, then a watchdog restart at edge 18
        repeat (2) tick();
        dbg_rst_req = 1'b1; sw_rst_req = 1'b1; tick();
        dbg_rst_req = 1'b0; sw_rst_req = 1'b0;
        ecnt = 0;
        t_check("dbgsw_outs", 32'(outs()), 32'b11111);
        t_check("dbgsw_cause", 32'(rst_cause), 32'b11000);
        wait_to(17);
        t_check("dbgsw_e17", 32'(outs()), 32'b01111);
        wdt_rst_req = 1'b1; tick(); wdt_rst_req = 1'b0;
        t_check("restart_outs", 32'(outs()), 32'b11111);
        t_check("restart_cause", 32'(rst_cause), 32'b11100);
        ecnt = 0;
        check_release("restart");
        t_check("restart_cause_run", 32'(rst_cause), 32'b11100);

        // 4. short button glitch ignored, long press resets
        repeat (2) tick();
        busy_seen = 1'b0;
        ext_rst_req = 1'b1;
        repeat (5) begin tick(); busy_seen |= seq_busy; end
        ext_rst_req = 1'b0;
        repeat (15) begin tick(); busy_seen |= seq_busy; end
        t_check("ext_short_busy", 32'(busy_seen), 32'b0);
        t_check("ext_short_cause", 32'(rst_cause), 32'b11100);
        ext_rst_req = 1'b1;
        ecnt = 0;
        wait_to(10); t_check("ext_e10", 32'(outs()), 32'b00000);
        wait_to(11); t_check("ext_e11", 32'(outs()), 32'b11111);
        t_check("ext_cause", 32'(rst_cause), 32'b00010);
        wait_to(40); t_check("ext_held", 32'(outs()), 32'b11111);
        ext_rst_req = 1'b0;
        wait_to(65); t_check("ext_rel_e65", 32'(outs()), 32'b11111);
        wait_to(66); t_check("ext_rel_e66", 32'(outs()), 32'b01111);
        wait_to(73); t_check("ext_rel_e73", 32'(outs()), 32'b00011);
        wait_to(74); t_check("ext_rel_e74", 32'(outs()), 32'b00000);

        // 5. board reset during REL_PER
        repeat (2) tick();
        sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
        ecnt = 0;
        t_check("sw_cause", 32'(rst_cause), 32'b10000);
        wait_to(21);
        t_check("relper_outs", 32'(outs()), 32'b00011);
        reset = 1'b1; tick();
        t_check("midrst_outs", 32'(outs()), 32'b11111);
        t_check("midrst_cause", 32'(rst_cause), 32'b00001);
        reset = 1'b0;
        ecnt = 0;
        check_release("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
